// File: rtl/sigmoid_pkg.sv
// rtl/sigmoid_pkg.sv - Q8.24 format, segment boundaries, mid values and codes for the sigmoid front end
package sigmoid_pkg;

  localparam int FRAC_BITS = 24;

  localparam logic [31:0] B1    = 32'd1 << FRAC_BITS;
  localparam logic [31:0] B2    = 32'd2 << FRAC_BITS;
  localparam logic [31:0] B3    = 32'd3 << FRAC_BITS;
  localparam logic [31:0] B4    = 32'd4 << FRAC_BITS;
  localparam logic [31:0] B_SAT = 32'd6 << FRAC_BITS;

  localparam logic [31:0] MID0 = 32'h0000_0000;
  localparam logic [31:0] MID1 = 32'h0180_0000;
  localparam logic [31:0] MID2 = 32'h0280_0000;
  localparam logic [31:0] MID3 = 32'h0380_0000;
  localparam logic [31:0] MID4 = 32'h0500_0000;
  localparam logic [31:0] MID5 = 32'h0500_0000;

  localparam logic [2:0] SEG0 = 3'd0;
  localparam logic [2:0] SEG1 = 3'd1;
  localparam logic [2:0] SEG2 = 3'd2;
  localparam logic [2:0] SEG3 = 3'd3;
  localparam logic [2:0] SEG4 = 3'd4;
  localparam logic [2:0] SEG5 = 3'd5;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] mid;
    logic        sat;
  } seg_t;

endpackage

// File: rtl/sigmoid_seg_sel_if.sv
// rtl/sigmoid_seg_sel_if.sv - operand in / segment result out handshake bundle
interface sigmoid_seg_sel_if #(
  parameter int DWIDTH = 32,
  parameter int SELW   = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] x_in;
  logic              out_valid;
  logic              out_ready;
  logic [SELW-1:0]   sel;
  logic [DWIDTH-1:0] mid;
  logic [DWIDTH-1:0] delta;
  logic              neg;
  logic              sat;

  modport master (
    output in_valid, x_in, out_ready,
    input  in_ready, out_valid, sel, mid, delta, neg, sat
  );

  modport slave (
    input  in_valid, x_in, out_ready,
    output in_ready, out_valid, sel, mid, delta, neg, sat
  );
endinterface

// File: rtl/sig_seg_cmp.sv
// rtl/sig_seg_cmp.sv - combinational |x| to segment code, expansion point and saturation flag
module sig_seg_cmp
  import sigmoid_pkg::*;
(
  input  logic [31:0] abs_x,
  output seg_t        seg
);

  // Lower bound of each segment is inclusive; |x| is never negative here.
  always_comb begin
    seg = '{SEG0, MID0, 1'b0};
    if (abs_x >= B_SAT)   seg = '{SEG5, MID5, 1'b1};
    else if (abs_x >= B4) seg = '{SEG4, MID4, 1'b0};
    else if (abs_x >= B3) seg = '{SEG3, MID3, 1'b0};
    else if (abs_x >= B2) seg = '{SEG2, MID2, 1'b0};
    else if (abs_x >= B1) seg = '{SEG1, MID1, 1'b0};
  end

endmodule

// File: rtl/sigmoid_seg_sel.sv
// rtl/sigmoid_seg_sel.sv - two-stage valid/ready front end: |x| and sign, then segment, mid and delta
module sigmoid_seg_sel
  import sigmoid_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int SELW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  sigmoid_seg_sel_if.slave     bus
);

  logic              adv1, adv2;
  logic              s1_valid, s1_neg, s2_valid;
  logic [DWIDTH-1:0] x_abs, s1_abs;
  logic [SELW-1:0]   sel_q;
  logic [DWIDTH-1:0] mid_q, delta_q;
  logic              neg_q, sat_q;
  seg_t              seg;

  assign adv2 = !s2_valid || bus.out_ready;
  assign adv1 = !s1_valid || adv2;

  // Most negative operand has no positive twin; clamp it to the largest magnitude.
  always_comb begin
    x_abs = bus.x_in;
    if (bus.x_in[DWIDTH-1]) begin
      if (bus.x_in == {1'b1, {(DWIDTH-1){1'b0}}})
        x_abs = {1'b0, {(DWIDTH-1){1'b1}}};
      else
        x_abs = -bus.x_in;
    end
  end

  sig_seg_cmp u_cmp (
    .abs_x (s1_abs),
    .seg   (seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_neg   <= 1'b0;
      s1_abs   <= '0;
      s2_valid <= 1'b0;
      sel_q    <= '0;
      mid_q    <= '0;
      delta_q  <= '0;
      neg_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= bus.in_valid;
        s1_neg   <= bus.x_in[DWIDTH-1];
        s1_abs   <= x_abs;
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        sel_q    <= seg.sel;
        mid_q    <= seg.mid;
        delta_q  <= s1_abs - seg.mid;
        neg_q    <= s1_neg;
        sat_q    <= seg.sat;
      end
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = s2_valid;
  assign bus.sel       = sel_q;
  assign bus.mid       = mid_q;
  assign bus.delta     = delta_q;
  assign bus.neg       = neg_q;
  assign bus.sat       = sat_q;

endmodule

// File: doc/sigmoid_seg_sel.md
Name: sigmoid_seg_sel

Overview:
- Front end of the sigmoid Maclaurin evaluator.
- Accepts a signed Q8.24 operand x and produces the following, all aligned on a 2-stage valid/ready pipeline:
  - 3-bit segment select code (0..5), the code the mid-value lookup consumes;
  - segment expansion point;
  - residual delta = |x| - mid;
  - sign flag and saturation flag.
- Sits between the neuron accumulator output and the polynomial multiply/accumulate stage.

Parameters:
- DWIDTH, 32, operand/result width, signed Q8.24 fixed point (bits 31:24 integer incl. sign, 23:0 fraction).
- SELW, 3, width of segment select code.

Ports:
- clk, input, 1, system clock, all state on rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, x_in valid.
- in_ready, output, 1, block can accept x_in this cycle.
- x_in, input, DWIDTH, signed Q8.24 operand.
- out_valid, output, 1, result fields valid.
- out_ready, input, 1, downstream accepts result.
- sel, output, SELW, segment code 0..5.
- mid, output, DWIDTH, expansion point for sel, Q8.24.
- delta, output, DWIDTH, signed |x| - mid, Q8.24.
- neg, output, 1, x_in was negative (downstream applies 1 - f(|x|)).
- sat, output, 1, |x| >= 6.0; downstream forces result to 1.0 (or 0.0 if neg).

Behaviour:
- Reset (rst=1 at clock edge):
  - s1_valid and s2_valid clear; out_valid=0.
  - sel=0, mid=0, delta=0, neg=0, sat=0.
  - in_ready=1 in the cycle after reset.
  - Reset mid-operation discards all in-flight data; no partial result is emitted.
- Handshake:
  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
  - Output fields are held stable while out_valid=1 and out_ready=0.
- Pipeline, latency 2 cycles from accept to out_valid when unstalled; throughput 1/cycle.
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1 (combinational from out_ready; no skid buffer).
- Stage 1, on adv1:
  - s1_valid <= in_valid.
  - s1_neg <= x_in[31].
  - s1_abs <= (x_in<0) ? -x_in : x_in.
  - x_in = 0x8000_0000 gives s1_abs = 0x7FFF_FFFF (saturating negate).
- Stage 2, on adv2:
  - s2_valid <= s1_valid.
  - Segment by s1_abs, unsigned compare, lower bound inclusive:
    - [0,1.0) -> sel 0, mid 0x0000_0000
    - [1.0,2.0) -> sel 1, mid 0x0180_0000 (1.5)
    - [2.0,3.0) -> sel 2, mid 0x0280_0000 (2.5)
    - [3.0,4.0) -> sel 3, mid 0x0380_0000 (3.5)
    - [4.0,6.0) -> sel 4, mid 0x0500_0000 (5.0)
    - >=6.0 -> sel 5, mid 0x0500_0000, sat=1
  - delta = s1_abs - mid, computed in DWIDTH two's complement. It cannot overflow because s1_abs <= 0x7FFF_FFFF and mid >= 0.
  - neg <= s1_neg.
  - sat is 0 for sel 0..4.
- Codes 6,7 are never produced.
- When a stage is not advancing, its registers hold. Bubbles (valid=0) propagate; data fields of invalid stages are don't-care but must not be X after reset.
- Simultaneous accept and output handshake in the same cycle: both occur; no data loss or duplication.

Decomposition:
- Shared package sigmoid_pkg:
  - localparams for Q8.24 format (FRAC_BITS=24);
  - segment boundaries B1..B4 = 1.0, 2.0, 3.0, 4.0, plus B_SAT=6.0;
  - mid-value constants MID0..MID5;
  - segment code constants SEG0..SEG5.
- One natural sub-module, sig_seg_cmp: combinational |x| -> {sel, mid, sat}, instantiated in stage 2.
- Abs/negate and the pipeline control stay in the top module.

Test Plan:
- x_in=0x0180_0000 (1.5), out_ready=1 -> two cycles later: sel=1, mid=0x0180_0000, delta=0, neg=0, sat=0.
- x_in=0xFD40_0000 (-2.75) -> sel=2, mid=0x0280_0000, delta=0x0040_0000, neg=1, sat=0.
- Boundaries:
  - x_in=0x0100_0000 (1.0) -> sel=1, delta=0xFF80_0000 (-0.5).
  - x_in=0x00FF_FFFF -> sel=0, delta=0x00FF_FFFF.
  - x_in=0x0600_0000 -> sel=5, sat=1, delta=0x0100_0000.
- x_in=0x8000_0000 -> neg=1, sat=1, sel=5, delta=0x7AFF_FFFF.
- Back-to-back stream of 8 values with out_ready low for 3 cycles mid-stream:
  - in_ready drops once both stages are full;
  - outputs are held stable while stalled;
  - all 8 results emerge in order, none dropped or duplicated.
- Assert rst for one cycle while both stages are valid -> next cycle out_valid=0, all outputs 0, in_ready=1; a new input is accepted and completes in 2 cycles.
